// File: rtl/avrspi_tx_if.sv
// AVR<->FPGA SPI pin bundle. The AVR is the master; the FPGA side uses the slave modport.
interface avrspi_tx_if;
  logic spics_n;   // chip select, active low
  logic spick;     // SPI clock, mode 0
  logic spido;     // AVR -> FPGA data (MOSI)
  logic spidi;     // FPGA -> AVR data (MISO)
  logic spiint_n;  // interrupt request to AVR, active low

  modport master (output spics_n, spick, spido, input  spidi, spiint_n);
  modport slave  (input  spics_n, spick, spido, output spidi, spiint_n);
endinterface

// File: rtl/avrspi_tx.sv
// Return path of the AVR<->FPGA SPI link.
// An address frame selects a register. During the following data frame that
// register is shifted out on spidi, LSB first. spiint_n flags a pending goal
// event. That flag is cleared by a complete 8-bit score read.
module avrspi_tx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [3:0]  DEV_ID      = 4'hA
) (
  input  logic        fclk,
  input  logic        game_reset,
  avrspi_tx_if.slave  spi,
  input  logic [3:0]  score_l,
  input  logic [3:0]  score_r,
  input  logic [7:0]  game_flags,
  input  logic        event_goal,
  output logic        rd_stb
);

  typedef enum logic {ADDR = 1'b0, DATA = 1'b1} phase_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d;
  logic [SYNC_STAGES-1:0] do_sync_q, do_sync_d;

  phase_e      phase_q, phase_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic        irq_pending_q, irq_pending_d;
  logic        spidi_q, spidi_d;
  logic        spiint_n_q, spiint_n_d;
  logic        rd_stb_q, rd_stb_d;

  logic        cs_s, cs_p, ck_s, ck_p, do_s;
  logic        cs_fall, cs_rise, ck_rise, ck_fall, cs_low;
  logic        rd_clr;
  logic [7:0]  reg_val;

  // Edges come from the oldest synchronizer stage and the one just before it.
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign cs_p    = cs_sync_q[SYNC_STAGES-2];
  assign ck_s    = ck_sync_q[SYNC_STAGES-1];
  assign ck_p    = ck_sync_q[SYNC_STAGES-2];
  assign do_s    = do_sync_q[SYNC_STAGES-1];
  assign cs_fall =  cs_s & ~cs_p;
  assign cs_rise = ~cs_s &  cs_p;
  assign ck_rise = ~ck_s &  ck_p;
  assign ck_fall =  ck_s & ~ck_p;
  assign cs_low  = ~cs_s;

  // Register file seen by the AVR. It is sampled once, at the data-frame CS fall.
  always_comb begin
    reg_val = 8'hFF;
    case (addr_q[7:4])
      4'h4:    reg_val = {score_r, score_l};
      4'h6:    reg_val = game_flags;
      4'h7:    reg_val = {irq_pending_q, 3'b000, DEV_ID};
      default: reg_val = 8'hFF;
    endcase
  end

  // Next-state logic for synchronizers, frame decode, shifter and IRQ.
  always_comb begin
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi.spics_n};
    ck_sync_d     = {ck_sync_q[SYNC_STAGES-2:0], spi.spick};
    do_sync_d     = {do_sync_q[SYNC_STAGES-2:0], spi.spido};
    phase_d       = phase_q;
    bit_cnt_d     = bit_cnt_q;
    addr_d        = addr_q;
    tx_sr_d       = tx_sr_q;

    // Phase alternates on every CS release. Short frames still count as a frame.
    if (cs_rise)
      phase_d = (phase_q == ADDR) ? DATA : ADDR;

    if (cs_fall) begin
      bit_cnt_d = 4'd0;
      if (phase_q == DATA)
        tx_sr_d = reg_val;
    end

    if (ck_rise && cs_low) begin
      if (bit_cnt_q < 4'd8)
        bit_cnt_d = bit_cnt_q + 4'd1;
      if (phase_q == ADDR)
        addr_d = {do_s, addr_q[7:1]};
    end

    // Shift in 1s so an over-long data frame reads back as all ones.
    if (ck_fall && cs_low && (phase_q == DATA))
      tx_sr_d = {1'b1, tx_sr_q[7:1]};

    // A complete 8-bit score read acknowledges the goal interrupt.
    rd_clr        = cs_rise && (phase_q == DATA) && (addr_q[7:4] == 4'h4) && (bit_cnt_q == 4'd8);
    irq_pending_d = event_goal | (irq_pending_q & ~rd_clr);
    rd_stb_d      = rd_clr;
    spiint_n_d    = ~irq_pending_d;
    spidi_d       = (cs_low && (phase_q == DATA)) ? tx_sr_d[0] : 1'b0;
  end

  // State registers. The asynchronous reset also realigns the frame phase.
  always_ff @(posedge fclk or posedge game_reset) begin
    if (game_reset) begin
      cs_sync_q     <= '1;
      ck_sync_q     <= '0;
      do_sync_q     <= '0;
      phase_q       <= ADDR;
      bit_cnt_q     <= 4'd0;
      addr_q        <= 8'h00;
      tx_sr_q       <= 8'hFF;
      irq_pending_q <= 1'b0;
      spidi_q       <= 1'b0;
      spiint_n_q    <= 1'b1;
      rd_stb_q      <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      ck_sync_q     <= ck_sync_d;
      do_sync_q     <= do_sync_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_q        <= addr_d;
      tx_sr_q       <= tx_sr_d;
      irq_pending_q <= irq_pending_d;
      spidi_q       <= spidi_d;
      spiint_n_q    <= spiint_n_d;
      rd_stb_q      <= rd_stb_d;
    end
  end

  assign spi.spidi    = spidi_q;
  assign spi.spiint_n = spiint_n_q;
  assign rd_stb       = rd_stb_q;

endmodule

// File: tb/tb_avrspi_tx.sv
// Bench for avrspi_tx. The AVR master is bit-banged. The checks run against a
// register/IRQ model of the link kept at transaction level.
module tb_avrspi_tx;
  localparam int         SYNC_STAGES = 2;
  localparam logic [3:0] DEV_ID      = 4'hA;

  logic       fclk = 1'b0;
  logic       game_reset = 1'b1;
  logic [3:0] score_l = 4'd0, score_r = 4'd0;
  logic [7:0] game_flags = 8'h00;
  logic       event_goal = 1'b0;
  logic       rd_stb;

  avrspi_tx_if spi();

  avrspi_tx #(.SYNC_STAGES(SYNC_STAGES), .DEV_ID(DEV_ID)) dut (
    .fclk(fclk), .game_reset(game_reset), .spi(spi.slave),
    .score_l(score_l), .score_r(score_r), .game_flags(game_flags),
    .event_goal(event_goal), .rd_stb(rd_stb)
  );

  always #5 fclk = ~fclk;

  int n_chk = 0, n_pass = 0;
  int rd_cnt = 0, exp_rd = 0;
  logic m_irq = 1'b0;

  always @(posedge fclk) if (rd_stb === 1'b1) rd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge fclk);
  endtask

  // Expected register contents from the register map and the model's IRQ flag.
  function automatic logic [7:0] ref_reg(input logic [7:0] a);
    case (a[7:4])
      4'h4:    return {score_r, score_l};
      4'h6:    return game_flags;
      4'h7:    return {m_irq, 3'b000, DEV_ID};
      default: return 8'hFF;
    endcase
  endfunction

  // One CS-framed burst of n clocks in SPI mode 0. MISO is sampled just before each rising edge.
  // If ev_at_rise is set, event_goal is pulsed on the fclk that processes the CS release.
  task automatic frame(input logic [7:0] mosi, input int n, input bit ev_at_rise,
                       output logic [15:0] miso);
    miso = '1;
    spi.spics_n = 1'b0;
    cyc(8);
    for (int i = 0; i < n; i++) begin
      spi.spido = (i < 8) ? mosi[i] : 1'b0;
      cyc(4);
      miso[i] = spi.spidi;
      spi.spick = 1'b1;
      cyc(8);
      spi.spick = 1'b0;
      cyc(4);
    end
    cyc(4);
    spi.spics_n = 1'b1;
    if (ev_at_rise) begin
      cyc(SYNC_STAGES - 1);
      event_goal = 1'b1;
      cyc(1);
      event_goal = 1'b0;
      cyc(8);
    end else cyc(8);
  endtask

  // Address frame followed by a data frame of nd clocks, all checked against the model.
  task automatic xact(input logic [7:0] a, input int nd, input bit collide, input string tag);
    logic [15:0] got, amiso, expw;
    logic [7:0]  expv;
    frame(a, 8, 1'b0, amiso);
    chk({tag, "/addr_miso"}, {24'h0, amiso[7:0]}, 32'h0);
    expv = ref_reg(a);
    for (int i = 0; i < 16; i++) expw[i] = (i < nd && i < 8) ? expv[i] : 1'b1;
    frame(8'h00, nd, collide, got);
    chk({tag, "/data"}, {16'h0, got}, {16'h0, expw});
    if (a[7:4] == 4'h4 && nd >= 8) begin
      m_irq = collide;
      exp_rd++;
    end
    cyc(4);
    chk({tag, "/spiint_n"}, {31'h0, spi.spiint_n}, {31'h0, ~m_irq});
    chk({tag, "/rd_stb_cnt"}, rd_cnt, exp_rd);
    chk({tag, "/idle_miso"}, {31'h0, spi.spidi}, 32'h0);
  endtask

  task automatic goal();
    event_goal = 1'b1;
    cyc(1);
    event_goal = 1'b0;
    m_irq = 1'b1;
    cyc(1);
    chk("goal/spiint_n", {31'h0, spi.spiint_n}, 32'h0);
  endtask

  initial begin
    logic [7:0] a;
    logic [15:0] junk;
    spi.spics_n = 1'b1; spi.spick = 1'b0; spi.spido = 1'b0;
    cyc(5);
    game_reset = 1'b0;
    cyc(20);
    chk("reset/spidi",    {31'h0, spi.spidi},    32'h0);
    chk("reset/spiint_n", {31'h0, spi.spiint_n}, 32'h1);
    chk("reset/rd_stb",   rd_cnt, 0);

    // Score read
    score_l = 4'd3; score_r = 4'd5;
    xact(8'h40, 8, 1'b0, "score53");

    // Goal IRQ, status read, clearing score read
    goal();
    xact(8'h70, 8, 1'b0, "status8A");
    xact(8'h40, 8, 1'b0, "clr");

    // Set and clear on the same cycle: set wins
    goal();
    xact(8'h40, 8, 1'b1, "collide");
    xact(8'h40, 8, 1'b0, "clr2");

    // Unmapped register, over-long frame; then aborted score read
    xact(8'h20, 12, 1'b0, "ff12");
    goal();
    xact(8'h40, 4, 1'b0, "abort4");

    // Reset during bit 3 of a data frame
    frame(8'h40, 8, 1'b0, junk);
    spi.spics_n = 1'b0;
    cyc(8);
    for (int i = 0; i < 3; i++) begin
      cyc(4); spi.spick = 1'b1; cyc(8);
      if (i < 2) begin spi.spick = 1'b0; cyc(4); end
    end
    game_reset = 1'b1;
    m_irq = 1'b0;
    cyc(2);
    chk("midrst/spidi",    {31'h0, spi.spidi},    32'h0);
    chk("midrst/spiint_n", {31'h0, spi.spiint_n}, 32'h1);
    spi.spick = 1'b0;
    spi.spics_n = 1'b1;
    cyc(4);
    game_reset = 1'b0;
    cyc(8);
    game_flags = 8'h81;
    xact(8'h60, 8, 1'b0, "flags81");

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      score_l = 4'($urandom); score_r = 4'($urandom); game_flags = 8'($urandom);
      if ($urandom_range(0, 2) == 0) goal();
      case ($urandom_range(0, 3))
        0: a = 8'h40 | 8'($urandom_range(0, 15));
        1: a = 8'h60 | 8'($urandom_range(0, 15));
        2: a = 8'h70 | 8'($urandom_range(0, 15));
        default: a = 8'($urandom);
      endcase
      xact(a, $urandom_range(4, 12), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
